// File: rtl/demux_pkg.sv
// Shared constants and types for the registered 1-to-4 demultiplexer.
package demux_pkg;

    localparam int DEMUX_N_OUT = 4;
    localparam int DEMUX_SEL_W = 2;

    localparam logic [DEMUX_SEL_W-1:0] SEL_A = 2'b00;
    localparam logic [DEMUX_SEL_W-1:0] SEL_B = 2'b01;
    localparam logic [DEMUX_SEL_W-1:0] SEL_C = 2'b10;
    localparam logic [DEMUX_SEL_W-1:0] SEL_D = 2'b11;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_e;

endpackage

// File: rtl/demux_1x4_reg_if.sv
// Input stream plus four output channels of demux_1x4_reg.
// The master side is the producer/consumer environment; the slave side is the demux.
interface demux_1x4_reg_if
    import demux_pkg::*;
#(
    parameter int WIDTH = 4
);
    logic                   in_valid;
    logic                   in_ready;
    logic [WIDTH-1:0]       in_data;
    logic [DEMUX_SEL_W-1:0] sel;
    logic [DEMUX_N_OUT-1:0] out_valid;
    logic [DEMUX_N_OUT-1:0] out_ready;
    logic [WIDTH-1:0]       a;
    logic [WIDTH-1:0]       b;
    logic [WIDTH-1:0]       c;
    logic [WIDTH-1:0]       d;

    modport master (
        output in_valid, in_data, sel, out_ready,
        input  in_ready, out_valid, a, b, c, d
    );

    modport slave (
        input  in_valid, in_data, sel, out_ready,
        output in_ready, out_valid, a, b, c, d
    );

endinterface

// File: rtl/demux_slot.sv
// One-entry valid/ready holding register feeding a single demux output channel.
//   state      | meaning
//   SLOT_EMPTY | no word held, out_valid=0, data keeps last value
//   SLOT_FULL  | word held and presented, stable until drained
module demux_slot
    import demux_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data
);

    slot_state_e state;

    // load is only raised when the slot is empty or draining this cycle,
    // so a load always wins and gives back-to-back throughput.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= SLOT_EMPTY;
            out_data <= '0;
        end else if (load) begin
            state    <= SLOT_FULL;
            out_data <= load_data;
        end else if (state == SLOT_FULL && out_ready) begin
            state <= SLOT_EMPTY;
        end
    end

    assign out_valid = (state == SLOT_FULL);

endmodule

// File: rtl/demux_1x4_reg.sv
// Registered 1-to-4 demultiplexer with per-channel holding slots.
// Define DEMUX_RR_EN to ignore sel and steer words round-robin a,b,c,d.
module demux_1x4_reg
    import demux_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    demux_1x4_reg_if.slave     bus
);

    logic [DEMUX_SEL_W-1:0]            dest;
    logic                              accept;
    logic [DEMUX_N_OUT-1:0]            slot_valid;
    logic [DEMUX_N_OUT-1:0][WIDTH-1:0] slot_data;

`ifdef DEMUX_RR_EN
    logic [DEMUX_SEL_W-1:0] rr_ptr;
    logic                   unused_sel;

    // Pointer only moves on an accepted word, so a stalled channel stalls the input.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= SEL_A;
        end else if (accept) begin
            rr_ptr <= rr_ptr + 1'b1;
        end
    end

    assign dest       = rr_ptr;
    assign unused_sel = ^bus.sel;
`else
    assign dest = bus.sel;
`endif

    assign bus.in_ready = ~slot_valid[dest] | bus.out_ready[dest];
    assign accept       = bus.in_valid & bus.in_ready;

    for (genvar k = 0; k < DEMUX_N_OUT; k++) begin : g_slot
        demux_slot #(.WIDTH(WIDTH)) u_slot (
            .clk       (clk),
            .rst_n     (rst_n),
            .load      (accept && (dest == DEMUX_SEL_W'(k))),
            .load_data (bus.in_data),
            .out_ready (bus.out_ready[k]),
            .out_valid (slot_valid[k]),
            .out_data  (slot_data[k])
        );
    end

    assign bus.out_valid = slot_valid;
    assign bus.a         = slot_data[SEL_A];
    assign bus.b         = slot_data[SEL_B];
    assign bus.c         = slot_data[SEL_C];
    assign bus.d         = slot_data[SEL_D];

endmodule

// File: tb/tb_demux_1x4_reg.sv
// Directed bench for demux_1x4_reg: per-channel expected-word queues filled at accept,
// compared and popped as each channel presents and drains its word.
module tb_demux_1x4_reg;
    import demux_pkg::*;

    localparam int WIDTH = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    demux_1x4_reg_if #(.WIDTH(WIDTH)) bus ();

    demux_1x4_reg #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [WIDTH-1:0]       exp_q [DEMUX_N_OUT][$];
    logic [DEMUX_SEL_W-1:0] rr_exp = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [WIDTH-1:0] ch_data(input int k);
        case (k)
            0:       return bus.a;
            1:       return bus.b;
            2:       return bus.c;
            default: return bus.d;
        endcase
    endfunction

    function automatic logic [DEMUX_N_OUT-1:0] exp_valid();
        logic [DEMUX_N_OUT-1:0] v;
        for (int k = 0; k < DEMUX_N_OUT; k++) v[k] = (exp_q[k].size() != 0);
        return v;
    endfunction

    task automatic clear_model();
        for (int k = 0; k < DEMUX_N_OUT; k++) exp_q[k].delete();
        rr_exp = '0;
    endtask

    // Called just after a falling edge: drive, check, advance the model across one rising edge.
    task automatic step(input logic v, input logic [1:0] s, input logic [WIDTH-1:0] dat,
                        input logic [3:0] ordy);
        logic [1:0] dst;
        logic       rdy_exp;
        bus.in_valid  = v;
        bus.sel       = s;
        bus.in_data   = dat;
        bus.out_ready = ordy;
        #1;
        check("out_valid", 32'(bus.out_valid), 32'(exp_valid()));
        for (int k = 0; k < DEMUX_N_OUT; k++)
            if (exp_q[k].size() != 0)
                check($sformatf("data[%0d]", k), 32'(ch_data(k)), 32'(exp_q[k][0]));
`ifdef DEMUX_RR_EN
        dst = rr_exp;
`else
        dst = s;
`endif
        rdy_exp = (exp_q[dst].size() == 0) || ordy[dst];
        check("in_ready", 32'(bus.in_ready), 32'(rdy_exp));
        @(posedge clk);
        for (int k = 0; k < DEMUX_N_OUT; k++)
            if (exp_q[k].size() != 0 && ordy[k]) void'(exp_q[k].pop_front());
        if (v && rdy_exp) begin
            exp_q[dst].push_back(dat);
            rr_exp = rr_exp + 1'b1;
        end
        @(negedge clk);
    endtask

    task automatic idle(input logic [3:0] ordy, input int n);
        for (int i = 0; i < n; i++) step(1'b0, 2'b00, 4'h0, ordy);
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.sel       = 2'b00;
        bus.in_data   = '0;
        bus.out_ready = 4'b0000;
        clear_model();

        // reset values
        #1;
        check("rst_out_valid", 32'(bus.out_valid), 32'h0);
        check("rst_a", 32'(bus.a), 32'h0);
        check("rst_b", 32'(bus.b), 32'h0);
        check("rst_c", 32'(bus.c), 32'h0);
        check("rst_d", 32'(bus.d), 32'h0);
        check("rst_in_ready", 32'(bus.in_ready), 32'h1);
        @(negedge clk);
        rst_n = 1'b1;
        idle(4'b0000, 2);

        // steer one word to each channel
        step(1'b1, SEL_A, 4'b0001, 4'b1111);
        step(1'b1, SEL_B, 4'b0010, 4'b1111);
        step(1'b1, SEL_C, 4'b0100, 4'b1111);
        step(1'b1, SEL_D, 4'b1000, 4'b1111);
        idle(4'b1111, 2);

        // stall on b, c keeps flowing, then b refills while draining
        step(1'b1, SEL_B, 4'b0010, 4'b1101);
        step(1'b1, SEL_B, 4'b0011, 4'b1101);
        step(1'b1, SEL_C, 4'b0100, 4'b1101);
        step(1'b0, SEL_B, 4'b1111, 4'b1101);
        step(1'b1, SEL_B, 4'b0011, 4'b1111);
        idle(4'b1111, 2);

        // back-to-back into d
        for (int i = 8; i < 16; i++) step(1'b1, SEL_D, 4'(i), 4'b1111);
        idle(4'b1111, 2);

        // asynchronous reset with words held in a and c
        step(1'b1, SEL_A, 4'b1010, 4'b0000);
        step(1'b1, SEL_C, 4'b0101, 4'b0000);
        step(1'b0, SEL_A, 4'b0000, 4'b0000);
        #3;
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 32'(bus.out_valid), 32'h0);
        check("midrst_a", 32'(bus.a), 32'h0);
        check("midrst_c", 32'(bus.c), 32'h0);
        clear_model();
        @(negedge clk);
        rst_n = 1'b1;
        idle(4'b1111, 3);

`ifdef DEMUX_RR_EN
        // round robin ignores sel
        step(1'b1, SEL_D, 4'b0001, 4'b1111);
        step(1'b1, SEL_D, 4'b0010, 4'b1111);
        step(1'b1, SEL_D, 4'b0100, 4'b1111);
        step(1'b1, SEL_D, 4'b1000, 4'b1111);
        step(1'b1, SEL_D, 4'b0011, 4'b1111);
        idle(4'b1111, 2);
        // c stalled: pointer parks at c until c drains
        for (int i = 0; i < 8; i++) step(1'b1, SEL_D, 4'(i + 1), 4'b1011);
        step(1'b1, SEL_D, 4'b1110, 4'b1111);
        step(1'b1, SEL_D, 4'b1101, 4'b1111);
        idle(4'b1111, 3);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
